// File: rtl/mem_access_ctrl.sv
// MEM-stage data SRAM access controller: issues one SRAM-like request per access,
// formats store strobes/data, aligns and extends load data, and raises address errors.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [2:0]  load_store_mem,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    input  logic        dm_addr_illegal,
    input  logic        flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] load_result,
    output logic        ex_adel,
    output logic        ex_ades,
    output logic [31:0] badvaddr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q, off_q;
    logic        wr_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  ld_type_q;
    logic        killed;

    logic        is_store, accept, bad_access;
    logic [1:0]  size_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    assign is_store   = load_store_mem[2] & (load_store_mem[1:0] != 2'b00);
    assign accept     = ~rst & (state == IDLE) & mem_valid & ~dm_addr_illegal & ~flush;
    assign bad_access = ~rst & (state == IDLE) & mem_valid &  dm_addr_illegal & ~flush;

    // Request formatting from the live MEM-stage inputs; captured on accept.
    always_comb begin
        size_d  = 2'd2;
        wstrb_d = '0;
        wdata_d = '0;
        case (load_store_mem)
            3'b000, 3'b001: size_d = 2'd0;
            3'b010, 3'b011: size_d = 2'd1;
            3'b101: begin
                size_d  = 2'd0;
                wstrb_d = 4'b0001 << mem_addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            3'b110: begin
                size_d  = 2'd1;
                wstrb_d = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            3'b111: begin
                wstrb_d = 4'b1111;
                wdata_d = store_data;
            end
            default: size_d = 2'd2;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (data_sram_addr_ok) state_nxt = WAIT;
            WAIT:    if (data_sram_data_ok) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            off_q     <= '0;
            wr_q      <= 1'b0;
            wstrb_q   <= '0;
            ld_type_q <= '0;
        end else if (accept) begin
            addr_q    <= mem_addr;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            off_q     <= mem_addr[1:0];
            wr_q      <= is_store;
            wstrb_q   <= wstrb_d;
            ld_type_q <= load_store_mem;
        end
    end

    // A squashed access still finishes its handshake; killed only suppresses its effects.
    always_ff @(posedge clk) begin
        if (rst)
            killed <= 1'b0;
        else if (state == DONE)
            killed <= 1'b0;
        else if ((state == REQ || state == WAIT) && flush)
            killed <= 1'b1;
    end

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = data_sram_rdata[7:0];
            2'd1:    rd_byte = data_sram_rdata[15:8];
            2'd2:    rd_byte = data_sram_rdata[23:16];
            default: rd_byte = data_sram_rdata[31:24];
        endcase
        rd_half = off_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (ld_type_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {24'd0, rd_byte};
            3'b010:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b011:  load_ext = {16'd0, rd_half};
            default: load_ext = data_sram_rdata;
        endcase
    end

    // A flush coinciding with data_ok counts as a kill for this response.
    always_ff @(posedge clk) begin
        if (rst)
            load_result <= '0;
        else if (state == WAIT && data_sram_data_ok && !wr_q && !killed && !flush)
            load_result <= load_ext;
    end

    assign data_sram_req   = (state == REQ);
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_wdata = wdata_q;

    assign mem_stall = accept | (~rst & ((state == REQ) | (state == WAIT)));
    assign mem_done  = (state == DONE) & ~killed;
    assign ex_adel   = bad_access & ~is_store;
    assign ex_ades   = bad_access &  is_store;
    assign badvaddr  = bad_access ? mem_addr : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: loads, stores, address errors,
// squashed accesses, reset mid-transaction and back-to-back accesses.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [2:0]  load_store_mem;
    logic [31:0] mem_addr, store_data;
    logic        dm_addr_illegal, flush;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_stall, mem_done, ex_adel, ex_ades;
    logic [31:0] load_result, badvaddr;

    int n_pass   = 0;
    int n_checks = 0;
    logic [31:0] lr_model;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .load_store_mem(load_store_mem),
        .mem_addr(mem_addr), .store_data(store_data), .dm_addr_illegal(dm_addr_illegal),
        .flush(flush), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
        .load_result(load_result), .ex_adel(ex_adel), .ex_ades(ex_ades), .badvaddr(badvaddr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        mem_valid = 1'b0; load_store_mem = 3'b000; mem_addr = '0; store_data = '0;
        dm_addr_illegal = 1'b0; flush = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    endtask

    task automatic load_txn(input logic [2:0] ls, input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [1:0] exp_size, input logic [31:0] exp_res);
        mem_valid = 1'b1; load_store_mem = ls; mem_addr = addr;
        settle();
        chk("ld_accept_stall", 32'(mem_stall), 32'd1);
        chk("ld_accept_noreq", 32'(data_sram_req), 32'd0);
        tick();
        mem_valid = 1'b0; data_sram_addr_ok = 1'b1;
        settle();
        chk("ld_req", 32'(data_sram_req), 32'd1);
        chk("ld_wr", 32'(data_sram_wr), 32'd0);
        chk("ld_wstrb", 32'(data_sram_wstrb), 32'd0);
        chk("ld_size", 32'(data_sram_size), 32'(exp_size));
        chk("ld_addr", data_sram_addr, addr);
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
        settle();
        chk("ld_wait_req", 32'(data_sram_req), 32'd0);
        chk("ld_wait_stall", 32'(mem_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;
        settle();
        chk("ld_done", 32'(mem_done), 32'd1);
        chk("ld_done_stall", 32'(mem_stall), 32'd0);
        chk("ld_result", load_result, exp_res);
        lr_model = exp_res;
        tick();
        settle();
        chk("ld_done_pulse", 32'(mem_done), 32'd0);
    endtask

    task automatic store_txn(input logic [2:0] ls, input logic [31:0] addr, input logic [31:0] sd,
                             input logic [1:0] exp_size, input logic [3:0] exp_wstrb,
                             input logic [31:0] exp_wdata);
        mem_valid = 1'b1; load_store_mem = ls; mem_addr = addr; store_data = sd;
        settle();
        tick();
        mem_valid = 1'b0; store_data = '0; data_sram_addr_ok = 1'b1;
        settle();
        chk("st_req", 32'(data_sram_req), 32'd1);
        chk("st_wr", 32'(data_sram_wr), 32'd1);
        chk("st_size", 32'(data_sram_size), 32'(exp_size));
        chk("st_wstrb", 32'(data_sram_wstrb), 32'(exp_wstrb));
        chk("st_wdata", data_sram_wdata, exp_wdata);
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
        settle();
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("st_done", 32'(mem_done), 32'd1);
        chk("st_keeps_result", load_result, lr_model);
        tick();
        settle();
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        mem_valid = 1'b1; load_store_mem = 3'b100; mem_addr = 32'h10;
        tick(); tick();
        settle();
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req", 32'(data_sram_req), 32'd0);
        chk("rst_done", 32'(mem_done), 32'd0);
        chk("rst_result", load_result, 32'd0);
        chk("rst_adel", 32'(ex_adel), 32'd0);
        chk("rst_badvaddr", badvaddr, 32'd0);
        lr_model = '0;
        drive_idle();
        rst = 1'b0;
        tick();

        // Load alignment / extension
        load_txn(3'b000, 32'h1003, 32'h80FF_1234, 2'd0, 32'hFFFF_FF80);
        load_txn(3'b001, 32'h1001, 32'h80FF_1234, 2'd0, 32'h0000_0012);
        load_txn(3'b010, 32'h1002, 32'h80FF_1234, 2'd1, 32'hFFFF_80FF);
        load_txn(3'b011, 32'h1000, 32'h80FF_1234, 2'd1, 32'h0000_1234);
        load_txn(3'b100, 32'h1000, 32'h80FF_1234, 2'd2, 32'h80FF_1234);

        // Store encodings
        store_txn(3'b101, 32'h2006, 32'h1234_56CD, 2'd0, 4'b0100, 32'hCDCD_CDCD);
        store_txn(3'b110, 32'h2000, 32'hAAAA_BEEF, 2'd1, 4'b0011, 32'hBEEF_BEEF);
        store_txn(3'b111, 32'h2008, 32'hDEAD_BEEF, 2'd2, 4'b1111, 32'hDEAD_BEEF);

        // sh with addr_ok held off for 4 cycles; a stray data_ok in REQ is ignored
        mem_valid = 1'b1; load_store_mem = 3'b110; mem_addr = 32'h2002; store_data = 32'hAAAA_BEEF;
        settle();
        tick();
        mem_valid = 1'b0; store_data = '0;
        for (int i = 0; i < 4; i++) begin
            data_sram_data_ok = (i == 1);
            settle();
            chk("sh_hold_req", 32'(data_sram_req), 32'd1);
            chk("sh_hold_wstrb", 32'(data_sram_wstrb), 32'hC);
            chk("sh_hold_wdata", data_sram_wdata, 32'hBEEF_BEEF);
            chk("sh_hold_addr", data_sram_addr, 32'h2002);
            tick();
        end
        data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b1;
        settle();
        chk("sh_size", 32'(data_sram_size), 32'd1);
        tick();
        data_sram_addr_ok = 1'b0;
        settle();
        chk("sh_wait_nodone", 32'(mem_done), 32'd0);
        tick();
        data_sram_data_ok = 1'b1;
        settle();
        chk("sh_wait2_stall", 32'(mem_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("sh_done", 32'(mem_done), 32'd1);
        tick();

        // addr_ok and data_ok together in REQ: data_ok must come again in WAIT
        mem_valid = 1'b1; load_store_mem = 3'b100; mem_addr = 32'h1000;
        settle();
        tick();
        mem_valid = 1'b0; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        settle();
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        settle();
        chk("same_wait_nodone", 32'(mem_done), 32'd0);
        chk("same_wait_stall", 32'(mem_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
        settle();
        chk("same_wait2_stall", 32'(mem_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("same_done", 32'(mem_done), 32'd1);
        chk("same_result", load_result, 32'h2222_2222);
        lr_model = 32'h2222_2222;
        tick();

        // Address errors
        mem_valid = 1'b1; load_store_mem = 3'b100; mem_addr = 32'h3001; dm_addr_illegal = 1'b1;
        settle();
        chk("adel", 32'(ex_adel), 32'd1);
        chk("adel_ades", 32'(ex_ades), 32'd0);
        chk("adel_badvaddr", badvaddr, 32'h3001);
        chk("adel_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("adel_noreq", 32'(data_sram_req), 32'd0);
        load_store_mem = 3'b111;
        settle();
        chk("ades", 32'(ex_ades), 32'd1);
        chk("ades_adel", 32'(ex_adel), 32'd0);
        flush = 1'b1;
        settle();
        chk("ades_flushed", 32'(ex_ades), 32'd0);
        drive_idle();
        settle();
        chk("exc_idle", 32'(ex_adel), 32'd0);
        tick();

        // Flush during WAIT: handshake completes, no done, result untouched
        mem_valid = 1'b1; load_store_mem = 3'b011; mem_addr = 32'h4002;
        settle();
        tick();
        mem_valid = 1'b0; data_sram_addr_ok = 1'b1;
        settle();
        tick();
        data_sram_addr_ok = 1'b0; flush = 1'b1;
        settle();
        tick();
        flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        settle();
        chk("kill_wait_stall", 32'(mem_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("kill_nodone", 32'(mem_done), 32'd0);
        chk("kill_result", load_result, lr_model);
        tick();
        load_txn(3'b011, 32'h4002, 32'h1234_5678, 2'd1, 32'h0000_1234);

        // Reset during WAIT abandons the access
        mem_valid = 1'b1; load_store_mem = 3'b100; mem_addr = 32'h5000;
        settle();
        tick();
        mem_valid = 1'b0; data_sram_addr_ok = 1'b1;
        settle();
        tick();
        data_sram_addr_ok = 1'b0; rst = 1'b1;
        settle();
        chk("rstw_stall", 32'(mem_stall), 32'd0);
        tick();
        rst = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777;
        settle();
        chk("rstw_req", 32'(data_sram_req), 32'd0);
        chk("rstw_stall_idle", 32'(mem_stall), 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("rstw_nodone", 32'(mem_done), 32'd0);
        chk("rstw_result", load_result, 32'd0);
        lr_model = '0;
        tick();

        // Back-to-back lw: the second is accepted in the IDLE cycle after DONE
        mem_valid = 1'b1; load_store_mem = 3'b100; mem_addr = 32'h10;
        settle();
        tick();
        data_sram_addr_ok = 1'b1;
        settle();
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0010;
        settle();
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("b2b_done1", 32'(mem_done), 32'd1);
        chk("b2b_done_stall", 32'(mem_stall), 32'd0);
        chk("b2b_done_noreq", 32'(data_sram_req), 32'd0);
        chk("b2b_result1", load_result, 32'hAAAA_0010);
        tick();
        mem_addr = 32'h14;
        settle();
        chk("b2b_idle_stall", 32'(mem_stall), 32'd1);
        chk("b2b_idle_noreq", 32'(data_sram_req), 32'd0);
        chk("b2b_idle_nodone", 32'(mem_done), 32'd0);
        tick();
        mem_valid = 1'b0;
        settle();
        chk("b2b_req2", 32'(data_sram_req), 32'd1);
        chk("b2b_addr2", data_sram_addr, 32'h14);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0014;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("b2b_done2", 32'(mem_done), 32'd1);
        chk("b2b_result2", load_result, 32'hAAAA_0014);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
